// File: rtl/seven_segment_scanner.sv
// Time-multiplexed, double-buffered common-anode 7-segment scanner with guard cycles.
// Optional LEADING_ZERO_BLANK_EN: suppress leading zero digits of the displayed value.
module seven_segment_scanner #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = 6 * DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GUARD_END  = PW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     shadow_q, shadow_d;
  logic [BW-1:0]     disp_q, disp_d;
  logic              pending_q, pending_d;
  logic [6:0]        seg_q, seg_d;
  logic              seg_dp_q, seg_dp_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              frame_done_q, frame_done_d;

  logic              presc_wrap, frame_wrap, in_guard;
  logic [BW-1:0]     in_bundle;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0] disp_dp, disp_blank, lz_blank;
  logic [3:0]        cur_nib;

  // Buffers are packed as {value, dp, blank}.
  assign in_bundle  = {value, dp, blank};
  assign disp_val   = disp_q[BW-1 -: 4*DIGITS];
  assign disp_dp    = disp_q[2*DIGITS-1:DIGITS];
  assign disp_blank = disp_q[DIGITS-1:0];
  assign cur_nib    = disp_val[{idx_q, 2'b00} +: 4];

  assign presc_wrap = (presc_q == PRESC_LAST);
  assign frame_wrap = presc_wrap && (idx_q == IDX_LAST);
  assign in_guard   = (presc_q < GUARD_END);

`ifdef LEADING_ZERO_BLANK_EN
  // zero_run[i] is set when nibbles i..DIGITS-1 of the displayed value are all zero.
  logic [DIGITS:0] zero_run;
  assign zero_run[DIGITS] = 1'b1;
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
    assign zero_run[gi] = zero_run[gi+1] & (disp_val[4*gi +: 4] == 4'h0);
  end
  assign lz_blank = zero_run[DIGITS-1:0] & ~DIGITS'(1);
`else
  assign lz_blank = '0;
`endif

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    presc_d      = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    disp_d       = disp_q;
    frame_done_d = frame_wrap;
    if (presc_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (load) begin
      shadow_d  = in_bundle;
      pending_d = 1'b1;
    end
    // A load coinciding with the frame boundary bypasses the shadow entirely.
    if (frame_wrap) begin
      if (load) begin
        disp_d    = in_bundle;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = shadow_q;
        pending_d = 1'b0;
      end
    end
  end

  always_comb begin
    seg_d    = 7'h7F;
    seg_dp_d = 1'b1;
    an_d     = '1;
    if (!in_guard) begin
      an_d[idx_q] = 1'b0;
      if (!disp_blank[idx_q]) begin
        seg_dp_d = ~disp_dp[idx_q];
        if (!lz_blank[idx_q]) begin
          seg_d = hex_to_seg(cur_nib);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      seg_q        <= 7'h7F;
      seg_dp_q     <= 1'b1;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      seg_dp_q     <= seg_dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign seg_dp     = seg_dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Randomized/directed bench for seven_segment_scanner against a cycle-count based display model.
module tb_seven_segment_scanner;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int GUARD    = 1;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        frame_done;

  seven_segment_scanner #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp(dp), .blank(blank),
    .seg(seg), .seg_dp(seg_dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  wire [12:0] obs = {an, seg, seg_dp, frame_done};

  int vectors = 0;
  int miscompares = 0;

  // Model: cycles since reset plus the displayed and shadowed {value, dp, blank}.
  int          cnt = 0;
  logic [15:0] m_val = '0, s_val = '0;
  logic [3:0]  m_dp = '0, s_dp = '0, m_blank = '0, s_blank = '0;
  logic        m_pending = 1'b0;
  logic [12:0] exp_vec;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic step();
    int presc, idx;
    logic wrap, sup;
    logic [3:0] an_e, nib;
    logic [6:0] seg_e;
    logic dp_e;
    @(posedge clk);
    if (!rst_n) begin
      exp_vec = {4'hF, 7'h7F, 1'b1, 1'b0};
      cnt = 0; m_val = '0; m_dp = '0; m_blank = '0;
      s_val = '0; s_dp = '0; s_blank = '0; m_pending = 1'b0;
    end else begin
      presc = cnt % SCAN_DIV;
      idx   = (cnt / SCAN_DIV) % DIGITS;
      wrap  = (cnt % FRAME) == FRAME - 1;
      an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1;
      if (presc >= GUARD) begin
        an_e[idx] = 1'b0;
        nib = 4'((m_val >> (4 * idx)) & 16'hF);
`ifdef LEADING_ZERO_BLANK_EN
        sup = (idx != 0) && ((m_val >> (4 * idx)) == 16'h0);
`else
        sup = 1'b0;
`endif
        if (!m_blank[idx]) begin
          dp_e = ~m_dp[idx];
          if (!sup) seg_e = seg_tab[nib];
        end
      end
      exp_vec = {an_e, seg_e, dp_e, wrap};
      if (wrap && load) begin
        m_val = value; m_dp = dp; m_blank = blank; m_pending = 1'b0;
      end else if (wrap && m_pending) begin
        m_val = s_val; m_dp = s_dp; m_blank = s_blank; m_pending = 1'b0;
      end else if (load) begin
        s_val = value; s_dp = dp; s_blank = blank; m_pending = 1'b1;
      end
      cnt++;
    end
    #1;
  endtask

  task automatic drive(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    load = ld; value = v; dp = d; blank = b;
    if (ld) $display("load value=%h dp=%b blank=%b at cycle %0d", v, d, b, cnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) begin
      step();
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", cnt, obs, exp_vec);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_frame();
    int pulses = 0;
    for (int i = 0; i < FRAME + 4; i++) begin
      step();
      if (i < FRAME + 1) pulses += int'(frame_done);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL idle_frame cyc=%0d got=%h exp=%h", cnt, obs, exp_vec);
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL frame_done_count got=%0d exp=1", pulses);
    end
  endtask

  task automatic run_frames(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      drive(1'b0, value, dp, blank);
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, cnt, obs, exp_vec);
      end
    end
  endtask

  task automatic test_mid_frame_load();
    while (cnt % FRAME != 6) run_frames("mid_align", 1);
    drive(1'b1, 16'h12AF, 4'h0, 4'h0);
    run_frames("mid_frame_load", 2 * FRAME + 2);
  endtask

  task automatic test_double_load();
    while (cnt % FRAME != 3) run_frames("dbl_align", 1);
    drive(1'b1, 16'h1111, 4'h0, 4'h0);
    run_frames("double_load_a", 5);
    drive(1'b1, 16'h2222, 4'h0, 4'h0);
    run_frames("double_load_b", 2 * FRAME);
  endtask

  task automatic test_wrap_load();
    while (cnt % FRAME != FRAME - 1) run_frames("wrap_align", 1);
    drive(1'b1, 16'h0007, 4'h0, 4'h0);
    run_frames("wrap_load", FRAME + 2);
  endtask

  task automatic test_dp_blank();
    while (cnt % FRAME != 9) run_frames("dpb_align", 1);
    drive(1'b1, 16'h8888, 4'b0100, 4'b0001);
    run_frames("dp_blank", 2 * FRAME);
  endtask

  task automatic test_reset_midframe();
    drive(1'b1, 16'h5A5A, 4'hF, 4'h0);
    run_frames("rstmid_pre", 1);
    while (cnt % SCAN_DIV != 2) run_frames("rstmid_align", 1);
    rst_n = 1'b0;
    step();
    vectors++;
    if (obs !== exp_vec) begin
      miscompares++;
      $display("FAIL reset_midframe cyc=%0d got=%h exp=%h", cnt, obs, exp_vec);
    end
    rst_n = 1'b1;
    run_frames("reset_midframe_post", 2 * FRAME + 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 700; i++) begin
      load  = ($urandom_range(0, 11) == 0);
      value = 16'($urandom);
      dp    = 4'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 5) == 0) value = value & 16'h00FF;
      rst_n = ($urandom_range(0, 249) != 0);
      if (load) $display("load value=%h dp=%b blank=%b at cycle %0d", value, dp, blank, cnt);
      step();
      vectors++;
      if (obs !== exp_vec) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cnt, obs, exp_vec);
      end
    end
    rst_n = 1'b1;
    load = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_idle_frame();
    test_mid_frame_load();
    test_double_load();
    test_wrap_load();
    test_dp_blank();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
